// File: rtl/pattern_match_module_pkg.sv
// Shared definitions for the streaming byte-pattern matcher.
//   - command opcodes and control-word field positions
//   - pattern / history size constants
//   - handshake FSM state encoding
//   - count clamping helper used for both LOAD length and DATA count
package pattern_match_module_pkg;

  // Command opcodes carried in INP_CONTROL[15:14]
  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_DATA  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // Control-word field positions
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 14;
  localparam int MASK_HI = 11;
  localparam int MASK_LO = 4;
  localparam int CNT_HI  = 3;
  localparam int CNT_LO  = 0;

  // Pattern and history sizes in bytes
  localparam int MAX_LEN  = 8;
  localparam int HIST_LEN = 7;

  // Width of {current beat, history} in bits
  localparam int TEXT_W = (MAX_LEN + HIST_LEN) * 8;

  // Handshake FSM states
  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_e;

  // Count fields above 8 saturate at 8
  function automatic logic [3:0] clamp_count(input logic [3:0] cnt);
    if (cnt > 4'd8) begin
      return 4'd8;
    end else begin
      return cnt;
    end
  endfunction

endpackage

// File: rtl/pattern_match_module_pm_window_compare.sv
// Combinational window comparator.
//   text_i    : {current beat bytes 7..0, history bytes 6..0}; byte j of the
//               vector is stream position j, history byte 6 is the most
//               recent history byte, combined byte 7 is current byte 0.
//   pattern_i : pattern bytes, byte 0 first
//   mask_i    : per-byte don't-care mask
//   len_i     : pattern length (values above 8 are treated as 8)
//   match_o   : bit k set when the window ending at current byte k matches.
// Length 0 yields a vacuous match; the caller gates that case.
module pm_window_compare
  import pattern_match_module_pkg::*;
(
  input  logic [TEXT_W-1:0]    text_i,
  input  logic [MAX_LEN*8-1:0] pattern_i,
  input  logic [MAX_LEN-1:0]   mask_i,
  input  logic [3:0]           len_i,
  output logic [MAX_LEN-1:0]   match_o
);

  logic [3:0] len_s;
  logic       hit_s;
  int         idx_s;

  // Evaluate every candidate window ending inside the current beat
  always_comb begin
    len_s   = clamp_count(len_i);
    match_o = '0;
    hit_s   = 1'b1;
    idx_s   = 0;
    for (int k = 0; k < MAX_LEN; k++) begin
      hit_s = 1'b1;
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i < int'(len_s)) begin
          // Window ending at combined byte 7+k starts at 8+k-len
          idx_s = MAX_LEN + k - int'(len_s) + i;
          if (!mask_i[i] && (text_i[idx_s*8 +: 8] != pattern_i[i*8 +: 8])) begin
            hit_s = 1'b0;
          end else begin
            hit_s = hit_s;
          end
        end else begin
          hit_s = hit_s;
        end
      end
      match_o[k] = hit_s;
    end
  end

endmodule

// File: rtl/pattern_match_module.sv
// Streaming byte-pattern matcher (one PMM unit).
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   INP_DATA        64-bit payload, byte 0 earliest in the stream
//   INP_CONTROL     [15:14] opcode, [11:4] wildcard mask, [3:0] count
//   DATA_VALID      four-phase request, held with stable inputs until ack
//   READY_STATUS    four-phase acknowledge (registered level)
//   ACCEPTED_STATUS sticky "pattern found" flag (registered)
// One command executes on the IDLE edge that samples DATA_VALID high; the
// FSM then waits in ACK for DATA_VALID to drop before accepting more.
module pattern_match_module
  import pattern_match_module_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] INP_DATA,
  input  logic [15:0] INP_CONTROL,
  input  logic        DATA_VALID,
  output logic        READY_STATUS,
  output logic        ACCEPTED_STATUS
);

  // Registered state
  state_e                  state_q,    state_d;
  logic                    ready_q,    ready_d;
  logic                    found_q,    found_d;
  logic [MAX_LEN*8-1:0]    pattern_q,  pattern_d;
  logic [3:0]              len_q,      len_d;
  logic [MAX_LEN-1:0]      mask_q,     mask_d;
  logic [HIST_LEN*8-1:0]   hist_q,     hist_d;
  logic [3:0]              hist_cnt_q, hist_cnt_d;

  // Decoded command fields
  logic [1:0]              opcode_s;
  logic [MAX_LEN-1:0]      mask_field_s;
  logic [3:0]              cnt_s;
  logic [1:0]              ctrl_unused_s;

  // Datapath
  logic [TEXT_W-1:0]       text_s;
  logic [MAX_LEN-1:0]      match_s;
  logic [MAX_LEN-1:0]      hit_vec_s;
  logic [HIST_LEN*8-1:0]   hist_next_s;
  logic [3:0]              hist_cnt_next_s;
  logic [4:0]              cnt_sum_s;

  assign opcode_s      = INP_CONTROL[OPC_HI:OPC_LO];
  assign mask_field_s  = INP_CONTROL[MASK_HI:MASK_LO];
  assign cnt_s         = clamp_count(INP_CONTROL[CNT_HI:CNT_LO]);
  assign ctrl_unused_s = INP_CONTROL[13:12];

  assign text_s = {INP_DATA, hist_q};

  pm_window_compare u_cmp (
    .text_i    (text_s),
    .pattern_i (pattern_q),
    .mask_i    (mask_q),
    .len_i     (len_q),
    .match_o   (match_s)
  );

  // Keep only windows that end on a valid byte and lie inside known history
  always_comb begin
    hit_vec_s = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if ((len_q != 4'd0) && (k < int'(cnt_s)) &&
          ((k + 1 + int'(hist_cnt_q)) >= int'(len_q))) begin
        hit_vec_s[k] = match_s[k];
      end else begin
        hit_vec_s[k] = 1'b0;
      end
    end
  end

  // New history = the 7 stream bytes ending at the last valid byte
  always_comb begin
    hist_next_s = '0;
    for (int j = 0; j < HIST_LEN; j++) begin
      hist_next_s[j*8 +: 8] = text_s[(int'(cnt_s) + j)*8 +: 8];
    end
    cnt_sum_s = {1'b0, hist_cnt_q} + {1'b0, cnt_s};
    if (cnt_sum_s > 5'd7) begin
      hist_cnt_next_s = 4'd7;
    end else begin
      hist_cnt_next_s = cnt_sum_s[3:0];
    end
  end

  // Next-state logic for the handshake FSM and command execution
  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    found_d    = found_q;
    pattern_d  = pattern_q;
    len_d      = len_q;
    mask_d     = mask_q;
    hist_d     = hist_q;
    hist_cnt_d = hist_cnt_q;
    case (state_q)
      IDLE: begin
        if (DATA_VALID) begin
          state_d = ACK;
          ready_d = 1'b1;
          case (opcode_s)
            OP_NOP: begin
              found_d = found_q;
            end
            OP_LOAD: begin
              pattern_d  = INP_DATA;
              len_d      = cnt_s;
              mask_d     = mask_field_s;
              hist_d     = '0;
              hist_cnt_d = 4'd0;
              found_d    = 1'b0;
            end
            OP_DATA: begin
              hist_d     = hist_next_s;
              hist_cnt_d = hist_cnt_next_s;
              found_d    = found_q | (|hit_vec_s);
            end
            OP_CLEAR: begin
              hist_d     = '0;
              hist_cnt_d = 4'd0;
              found_d    = 1'b0;
            end
            default: begin
              found_d = found_q;
            end
          endcase
        end else begin
          state_d = IDLE;
          ready_d = 1'b0;
        end
      end
      ACK: begin
        if (!DATA_VALID) begin
          state_d = IDLE;
          ready_d = 1'b0;
        end else begin
          state_d = ACK;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  // State, configuration, history and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      found_q    <= 1'b0;
      pattern_q  <= '0;
      len_q      <= 4'd0;
      mask_q     <= '0;
      hist_q     <= '0;
      hist_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      found_q    <= found_d;
      pattern_q  <= pattern_d;
      len_q      <= len_d;
      mask_q     <= mask_d;
      hist_q     <= hist_d;
      hist_cnt_q <= hist_cnt_d;
    end
  end

  assign READY_STATUS    = ready_q;
  assign ACCEPTED_STATUS = found_q;

endmodule

// File: tb/tb_pattern_match_module.sv
module tb_pattern_match_module;

  logic        clk;
  logic        rst_n;
  logic [63:0] INP_DATA;
  logic [15:0] INP_CONTROL;
  logic        DATA_VALID;
  logic        READY_STATUS;
  logic        ACCEPTED_STATUS;

  int total;
  int bad;
  bit exp_q[$];
  logic ready_prev;

  localparam logic [1:0] NOP   = 2'b00;
  localparam logic [1:0] LOAD  = 2'b01;
  localparam logic [1:0] DATA  = 2'b10;
  localparam logic [1:0] CLEAR = 2'b11;

  pattern_match_module dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .INP_DATA        (INP_DATA),
    .INP_CONTROL     (INP_CONTROL),
    .DATA_VALID      (DATA_VALID),
    .READY_STATUS    (READY_STATUS),
    .ACCEPTED_STATUS (ACCEPTED_STATUS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: on every rise of READY_STATUS pop the expected flag and compare
  initial begin
    ready_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && READY_STATUS && !ready_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          chk("accepted", {31'd0, ACCEPTED_STATUS}, {31'd0, exp_q.pop_front()});
        end
      end
      ready_prev = READY_STATUS;
    end
  end

  // One four-phase handshake; valid held for 'hold' clock edges
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] mask, input logic [3:0] cnt,
                        input logic [63:0] data, input bit exp, input int hold);
    INP_DATA    = data;
    INP_CONTROL = {op, 2'b00, mask, cnt};
    exp_q.push_back(exp);
    DATA_VALID  = 1'b1;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("ready_high", {31'd0, READY_STATUS}, 32'd1);
    end
    DATA_VALID = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ready_low", {31'd0, READY_STATUS}, 32'd0);
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    DATA_VALID  = 1'b0;
    INP_DATA    = 64'd0;
    INP_CONTROL = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, READY_STATUS}, 32'd0);
    chk("rst_accepted", {31'd0, ACCEPTED_STATUS}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic match inside one beat
    do_cmd(LOAD,  8'h00, 4'd3, 64'h0000_0000_0043_4241, 1'b0, 1);
    do_cmd(DATA,  8'h00, 4'd8, 64'h7878_7843_4241_7878, 1'b1, 1);
    // Cross-beat match
    do_cmd(LOAD,  8'h00, 4'd4, 64'h0000_0000_4443_4241, 1'b0, 1);
    do_cmd(DATA,  8'h00, 4'd8, 64'h4342_4178_7878_7878, 1'b0, 1);
    do_cmd(DATA,  8'h00, 4'd8, 64'h7979_7979_7979_7944, 1'b1, 1);
    // Wildcard
    do_cmd(LOAD,  8'h02, 4'd3, 64'h0000_0000_0043_0041, 1'b0, 1);
    do_cmd(DATA,  8'h00, 4'd3, 64'h0000_0000_0043_5A41, 1'b1, 1);
    do_cmd(CLEAR, 8'h00, 4'd0, 64'h0,                   1'b0, 1);
    do_cmd(DATA,  8'h00, 4'd3, 64'h0000_0000_0044_5A41, 1'b0, 1);
    // Pattern only beyond count; count 0 keeps history; partial-beat cross match
    do_cmd(CLEAR, 8'h00, 4'd0, 64'h0,                   1'b0, 1);
    do_cmd(DATA,  8'h00, 4'd2, 64'h0000_0043_5A41_7171, 1'b0, 1);
    do_cmd(DATA,  8'h00, 4'd1, 64'h0000_0000_0000_0041, 1'b0, 1);
    do_cmd(DATA,  8'h00, 4'd0, 64'h4343_4343_4343_4343, 1'b0, 1);
    do_cmd(DATA,  8'h00, 4'd2, 64'h0000_0000_0000_435A, 1'b1, 1);
    // Window reaching before history start must not match
    do_cmd(LOAD,  8'h01, 4'd2, 64'h0000_0000_0000_4200, 1'b0, 1);
    do_cmd(DATA,  8'h00, 4'd1, 64'h0000_0000_0000_0042, 1'b0, 1);
    do_cmd(DATA,  8'h00, 4'd1, 64'h0000_0000_0000_0042, 1'b1, 1);
    // Count clamp (15 -> 8, 12 -> 8) with full-length pattern
    do_cmd(LOAD,  8'h00, 4'd15, 64'h4847_4645_4443_4241, 1'b0, 1);
    do_cmd(DATA,  8'h00, 4'd12, 64'h4847_4645_4443_4241, 1'b1, 1);
    // Length 0 never matches
    do_cmd(LOAD,  8'h00, 4'd0, 64'h4141_4141_4141_4141, 1'b0, 1);
    do_cmd(DATA,  8'h00, 4'd8, 64'h4141_4141_4141_4141, 1'b0, 1);
    // Sticky flag survives NOP
    do_cmd(LOAD,  8'h00, 4'd1, 64'h0000_0000_0000_0041, 1'b0, 1);
    do_cmd(DATA,  8'h00, 4'd1, 64'h0000_0000_0000_0041, 1'b1, 1);
    do_cmd(NOP,   8'h00, 4'd0, 64'h0,                   1'b1, 1);
    // Valid held 5 cycles executes once: a repeat would form "AA"
    do_cmd(LOAD,  8'h00, 4'd2, 64'h0000_0000_0000_4141, 1'b0, 1);
    do_cmd(DATA,  8'h00, 4'd1, 64'h0000_0000_0000_0041, 1'b0, 5);
    do_cmd(DATA,  8'h00, 4'd1, 64'h0000_0000_0000_0041, 1'b1, 1);

    // Reset during ACK with flag set drops both outputs without a clock edge
    INP_DATA    = 64'd0;
    INP_CONTROL = {DATA, 2'b00, 8'h00, 4'd0};
    exp_q.push_back(1'b1);
    DATA_VALID  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ack_before_rst", {31'd0, READY_STATUS}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_ready", {31'd0, READY_STATUS}, 32'd0);
    chk("async_rst_accepted", {31'd0, ACCEPTED_STATUS}, 32'd0);
    DATA_VALID = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // Pattern was reset to length 0
    do_cmd(DATA,  8'h00, 4'd8, 64'h4141_4141_4141_4141, 1'b0, 1);

    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
